pc_gen: RTL
===========

Name: pc_gen

Overview:
- Parametrised fetch-stage program-counter generator; successor to the single-register PC.
- Holds the fetch PC and selects the next PC from several sources:
  - sequential +4, or +2 when compressed instructions are enabled
  - execute-stage branch/jump redirect
  - trap entry
  - trap return (mret), using an internal EPC register
- Adds a fetch valid/ready handshake, halt/resume control and misaligned-target trapping.
- Sits between the hazard unit / execute stage and instruction memory.

Parameters:
- XLEN, 32, PC and data width in bits.
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- TRAP_VECTOR, 32'h0000_0100, PC loaded on trap entry or misaligned redirect.
- C_EXT, 0, 1 = 16-bit instruction alignment allowed, enabling +2 step and 2-byte target check; 0 = 4-byte only.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, hazard hold; PC keeps its value.
- fetch_ready, input, 1, instruction memory accepts the current pc_out.
- pc_out, output, XLEN, current fetch address.
- pc_valid, output, 1, pc_out is a valid fetch request.
- step_half, input, 1, current instruction is 16-bit; ignored when C_EXT=0.
- redirect, input, 1, branch/jump taken in execute.
- redirect_pc, input, XLEN, branch/jump target.
- redirect_src_pc, input, XLEN, PC of the redirecting instruction.
- trap, input, 1, take exception/interrupt.
- trap_epc, input, XLEN, return address saved on trap.
- mret, input, 1, return from trap.
- halt_req, input, 1, request halt (debug/low-power).
- resume, input, 1, leave halt.
- epc_out, output, XLEN, current EPC register value.
- misalign_exc, output, 1, one-cycle pulse: redirect target was misaligned.
- halted, output, 1, FSM is in ST_HALT.

Behaviour:
- Reset (sync, on a clk edge with reset=1):
  - pc_out=RESET_VECTOR, pc_valid=0, epc_out=0, misalign_exc=0, halted=0, state=ST_BOOT.
  - Reset overrides every other input, including mid-redirect and mid-halt.
- FSM states:
  - ST_BOOT: exactly one cycle; pc_valid=0; next state ST_RUN with pc_out unchanged (RESET_VECTOR).
  - ST_RUN: pc_valid=1.
  - ST_HALT: pc_valid=0, halted=1; pc_out held.
- Advance condition: adv = pc_valid & fetch_ready & ~stall.
- Next-PC priority in ST_RUN, highest first, evaluated each cycle:
  1. trap: pc<=TRAP_VECTOR, epc<=trap_epc.
  2. mret: pc<=epc_out.
  3. redirect with misaligned redirect_pc: pc<=TRAP_VECTOR, epc<=redirect_src_pc, misalign_exc=1 for the next cycle only.
     - Misaligned means bit[1]!=0 when C_EXT=0, or bit[0]!=0 when C_EXT=1.
  4. redirect, aligned: pc<=redirect_pc.
  5. halt_req: state<=ST_HALT, pc held.
  6. adv: pc<=pc_out + (C_EXT & step_half ? 2 : 4).
  7. Otherwise pc held.
- Items 1–4 are flushes:
  - They take effect regardless of stall or fetch_ready; stall never blocks a redirect.
  - A flush takes precedence over halt_req in the same cycle; the halt is taken next cycle if halt_req is still high.
- ST_HALT:
  - resume -> ST_RUN next cycle.
  - trap in ST_HALT: pc<=TRAP_VECTOR, epc<=trap_epc, state<=ST_RUN (wake on interrupt).
  - redirect and mret are ignored in ST_HALT.
  - resume and halt_req both high -> resume wins.
- Latency: one cycle from any input to pc_out/pc_valid change. All outputs are registered.
- Arithmetic: increment wraps modulo 2^XLEN (32'hFFFF_FFFC + 4 -> 0); no overflow flag.
- ST_BOOT ignores all inputs except reset.
- epc changes only on trap or misaligned-redirect capture.

Decomposition:
- Shared package (riscv_pkg) holds:
  - state encoding localparams ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALT=2'd2.
  - default vector constants.
  - the alignment-check function.
- No sub-module: a single FSM plus next-PC mux. The EPC register stays inline.

Test Plan:
- Reset, then fetch_ready=1 for 4 cycles -> pc_valid rises one cycle after ST_BOOT; pc_out sequence 0,4,8,12.
- stall=1 while pc_out=8, redirect=1 to 32'h40 in the same cycle -> next pc_out=32'h40 (redirect beats stall); stall then held 2 cycles -> pc stays 32'h40.
- C_EXT=1, step_half=1 at pc 32'h10 -> 32'h12. Redirect to 32'h13 with src 32'h20 -> pc=TRAP_VECTOR, epc_out=32'h20, misalign_exc high exactly 1 cycle.
- trap with trap_epc=32'h84 and redirect in the same cycle -> pc=32'h100, epc=32'h84. mret two cycles later -> pc=32'h84.
- halt_req at pc 32'h8 -> halted=1, pc_valid=0, pc holds 32'h8. resume -> pc_valid=1 and the sequence continues from 32'h8. A second halt followed by trap -> wakes with pc=32'h100.
- Reset asserted in ST_HALT and again mid-redirect -> pc=RESET_VECTOR, pc_valid=0 next cycle; epc_out=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: PC FSM state encoding, default vectors and
// the redirect-target alignment check.
package riscv_pkg;

  typedef logic [1:0] pc_state_t;

  localparam pc_state_t ST_BOOT = 2'd0;
  localparam pc_state_t ST_RUN  = 2'd1;
  localparam pc_state_t ST_HALT = 2'd2;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  // With compressed instructions only bit 0 matters; otherwise bit 1 flags a misaligned target.
  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic c_ext);
    return c_ext ? addr_lo[0] : addr_lo[1];
  endfunction

endpackage

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: boot/run/halt FSM, prioritised
// next-PC selection, EPC capture and misaligned-redirect trapping.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(DEF_TRAP_VECTOR),
  parameter bit              C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  input  logic            step_half,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic [XLEN-1:0] redirect_src_pc,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_epc,
  input  logic            mret,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] epc_out,
  output logic            misalign_exc,
  output logic            halted
);

  pc_state_t       state, state_nxt;
  logic [XLEN-1:0] pc_nxt, epc_nxt, step;
  logic            misalign_nxt, valid_nxt, halted_nxt;
  logic            adv, redir_bad, flush;

  assign adv       = pc_valid & fetch_ready & ~stall;
  assign redir_bad = is_misaligned(redirect_pc[1:0], C_EXT);
  assign flush     = trap | mret | redirect;
  assign step      = (C_EXT && step_half) ? XLEN'(2) : XLEN'(4);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  if (!flush && halt_req) state_nxt = ST_HALT;
      ST_HALT: if (resume || trap) state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  // Next values of the registered outputs; flushes ignore stall and fetch_ready
  always_comb begin
    pc_nxt       = pc_out;
    epc_nxt      = epc_out;
    misalign_nxt = 1'b0;
    valid_nxt    = (state_nxt == ST_RUN);
    halted_nxt   = (state_nxt == ST_HALT);
    case (state)
      ST_RUN: begin
        if (trap) begin
          pc_nxt  = TRAP_VECTOR;
          epc_nxt = trap_epc;
        end else if (mret) begin
          pc_nxt = epc_out;
        end else if (redirect && redir_bad) begin
          pc_nxt       = TRAP_VECTOR;
          epc_nxt      = redirect_src_pc;
          misalign_nxt = 1'b1;
        end else if (redirect) begin
          pc_nxt = redirect_pc;
        end else if (!halt_req && adv) begin
          pc_nxt = pc_out + step;
        end
      end
      ST_HALT: begin
        if (trap) begin
          pc_nxt  = TRAP_VECTOR;
          epc_nxt = trap_epc;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_out       <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      epc_out      <= '0;
      misalign_exc <= 1'b0;
      halted       <= 1'b0;
    end else begin
      pc_out       <= pc_nxt;
      pc_valid     <= valid_nxt;
      epc_out      <= epc_nxt;
      misalign_exc <= misalign_nxt;
      halted       <= halted_nxt;
    end
  end

endmodule
